// File: rtl/gpio_capture_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_capture_fifo_if                                                     |
// | Valid/ready byte stream from the GPIO capture FIFO to its consumer.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface gpio_capture_fifo_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/gpio_capture_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_capture_fifo                                                        |
// | Commits GPIO bytes on GPIOEn falls into a show-ahead FIFO; counts frames.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gpio_capture_fifo #(
   parameter int DEPTH       = 16,
   parameter int FRAME_BYTES = 152100,
   parameter int CNT_W       = 18
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic [7:0]               GPIO,
   input  wire logic                     GPIOEn,
   gpio_capture_fifo_if.master           out_if,
   output logic [$clog2(DEPTH):0]        fifo_count,
   output logic                          overflow,
   output logic [CNT_W-1:0]              byte_count,
   output logic                          frame_done
);
   localparam int               C_AW    = $clog2(DEPTH);
   localparam int               C_CW    = C_AW + 1;
   localparam logic [C_CW-1:0]  C_DEPTH = C_CW'(DEPTH);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(FRAME_BYTES - 1);

   logic [7:0]      mem [DEPTH];
   logic            en_q;
   logic [7:0]      hold_q,     hold_d;
   logic [C_AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [C_AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [C_CW-1:0] count_q,    count_d;
   logic            overflow_q, overflow_d;
   logic [CNT_W-1:0] bcnt_q,    bcnt_d;
   logic            fdone_q,    fdone_d;
   logic            fall, pop, full, push;

   always_comb begin
      fall       = en_q & ~GPIOEn;
      pop        = (count_q != '0) & out_if.out_ready;
      full       = (count_q == C_DEPTH);
      // A full FIFO still takes the byte if the head leaves on the same edge.
      push       = fall & (~full | pop);
      hold_d     = GPIOEn ? GPIO : hold_q;
      wr_ptr_d   = push ? wr_ptr_q + C_AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + C_AW'(1) : rd_ptr_q;
      overflow_d = overflow_q | (fall & ~push);
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + C_CW'(1);
         2'b01:   count_d = count_q - C_CW'(1);
         default: count_d = count_q;
      endcase
      bcnt_d  = bcnt_q;
      fdone_d = 1'b0;
      if (fall) begin
         if (bcnt_q == C_LAST) begin
            bcnt_d  = '0;
            fdone_d = 1'b1;
         end else begin
            bcnt_d  = bcnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q       <= 1'b0;
         hold_q     <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         bcnt_q     <= '0;
         fdone_q    <= 1'b0;
      end else begin
         en_q       <= GPIOEn;
         hold_q     <= hold_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         bcnt_q     <= bcnt_d;
         fdone_q    <= fdone_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr_q] <= hold_q;
      end
   end

   assign out_if.out_data  = mem[rd_ptr_q];
   assign out_if.out_valid = (count_q != '0);
   assign fifo_count       = count_q;
   assign overflow         = overflow_q;
   assign byte_count       = bcnt_q;
   assign frame_done       = fdone_q;
endmodule
`default_nettype wire

// File: tb/tb_gpio_capture_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gpio_capture_fifo                                                     |
// | Table vectors, corner sequences and random traffic against a queue model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gpio_capture_fifo;
   localparam int DEPTH = 16;
   localparam int FRAME = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] GPIO;
   logic       GPIOEn;
   logic [4:0] fifo_count;
   logic       overflow;
   logic [17:0] byte_count;
   logic       frame_done;
   int         errors = 0;
   int         checks = 0;

   gpio_capture_fifo_if bus ();

   gpio_capture_fifo #(.DEPTH(DEPTH), .FRAME_BYTES(FRAME), .CNT_W(18)) dut (
      .clk        (clk),
      .rst        (rst),
      .GPIO       (GPIO),
      .GPIOEn     (GPIOEn),
      .out_if     (bus.master),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .byte_count (byte_count),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference: a byte queue plus the last sampled enable and held byte.
   logic [7:0] mq[$];
   bit         m_en   = 1'b0;
   logic [7:0] m_hold = 8'h00;
   bit         m_ovf  = 1'b0;
   int         m_cnt  = 0;
   bit         m_fd   = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_step(bit r, bit e, logic [7:0] g, bit rd);
      bit fall;
      logic [7:0] dummy;
      if (r) begin
         mq.delete();
         m_en = 0; m_hold = 8'h00; m_ovf = 0; m_cnt = 0; m_fd = 0;
         return;
      end
      fall = m_en && !e;
      if (mq.size() != 0 && rd) dummy = mq.pop_front();
      m_fd = 1'b0;
      if (fall) begin
         if (mq.size() < DEPTH) mq.push_back(m_hold);
         else m_ovf = 1'b1;
         m_cnt = (m_cnt + 1) % FRAME;
         m_fd  = (m_cnt == 0);
      end
      if (e) m_hold = g;
      m_en = e;
   endfunction

   function automatic void check_model();
      chk("valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("data", bus.out_data, mq[0]);
      chk("fifo_count", fifo_count, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("byte_count", byte_count, m_cnt);
      chk("frame_done", frame_done, m_fd);
   endfunction

   task automatic cycle(input bit r, input bit e, input logic [7:0] g, input bit rd);
      rst = r; GPIOEn = e; GPIO = g; bus.out_ready = rd;
      model_step(r, e, g, rd);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic strobe(input logic [7:0] b, input bit rd);
      cycle(0, 1, b, rd);
      cycle(0, 0, ~b, rd);
   endtask

   typedef struct {
      bit r; bit e; logic [7:0] g; bit rd;
      bit ev; logic [7:0] ed; int ec; int ebc; bit efd;
   } vec_t;
   vec_t tbl[14];

   initial begin
      rst = 1'b1; GPIOEn = 1'b0; GPIO = 8'h00; bus.out_ready = 1'b0;
      tbl[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0};
      tbl[1]  = '{0, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 0};
      tbl[2]  = '{0, 0, 8'hFF, 0, 1, 8'hA5, 1, 1, 0};
      tbl[3]  = '{0, 0, 8'hFF, 1, 0, 8'h00, 0, 1, 0};
      for (int i = 4; i < 9; i++) tbl[i] = '{0, 1, 8'h3C, 1, 0, 8'h00, 0, 1, 0};
      tbl[9]  = '{0, 0, 8'h00, 1, 1, 8'h3C, 1, 2, 0};
      for (int i = 10; i < 14; i++) tbl[i] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 2, 0};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].r, tbl[i].e, tbl[i].g, tbl[i].rd);
         chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].ev);
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].ed);
         chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].ec);
         chk($sformatf("tbl%0d_bcnt", i), byte_count, tbl[i].ebc);
         chk($sformatf("tbl%0d_fdone", i), frame_done, tbl[i].efd);
      end

      // Overfill: byte 16 is dropped, 0..15 drain in order.
      cycle(1, 0, 8'h00, 0);
      for (int i = 0; i < 17; i++) strobe(8'(i), 0);
      chk("ovf_count", fifo_count, 16);
      chk("ovf_flag", overflow, 1);
      for (int i = 0; i < 16; i++) begin
         chk("ovf_drain_valid", bus.out_valid, 1);
         chk("ovf_drain_data", bus.out_data, 8'(i));
         cycle(0, 0, 8'h00, 1);
      end
      chk("ovf_drained", bus.out_valid, 0);

      // Push into a full FIFO on the same edge as a pop.
      cycle(1, 0, 8'h00, 0);
      for (int i = 0; i < 16; i++) strobe(8'h10 + 8'(i), 0);
      cycle(0, 1, 8'h77, 0);
      cycle(0, 0, 8'h00, 1);
      chk("fullpop_ovf", overflow, 0);
      chk("fullpop_count", fifo_count, 16);
      for (int i = 0; i < 16; i++) begin
         chk("fullpop_data", bus.out_data, (i < 15) ? 8'h11 + 8'(i) : 8'h77);
         cycle(0, 0, 8'h00, 1);
      end
      chk("fullpop_empty", bus.out_valid, 0);

      // Frame wrap with FRAME_BYTES=4.
      cycle(1, 0, 8'h00, 1);
      for (int i = 0; i < 5; i++) begin
         strobe(8'h40 + 8'(i), 1);
         chk("frame_bcnt", byte_count, (i + 1) % 4);
         chk("frame_pulse", frame_done, i == 3);
      end
      cycle(0, 0, 8'h00, 1);
      chk("frame_pulse_gone", frame_done, 0);

      // Reset collides with buffered data and a falling enable.
      cycle(1, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) strobe(8'h90 + 8'(i), 0);
      cycle(0, 1, 8'h99, 0);
      cycle(1, 0, 8'h00, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_bcnt", byte_count, 0);
      chk("rst_ovf", overflow, 0);
      cycle(0, 0, 8'h00, 0);
      chk("rst_nopush", fifo_count, 0);

      // Random traffic: bursty enables, random back-pressure, rare resets.
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
               8'($urandom), $urandom_range(0, 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gpio_capture_fifo.md
Name: gpio_capture_fifo

Overview:
- Hardware receiver for the processor's 8-bit GPIO output port: GPIO data plus a GPIOEn strobe, where the byte is committed on the GPIOEn falling edge.
- Captures each committed byte and buffers it in a show-ahead FIFO.
- Presents bytes to a downstream consumer (display/UART/memory writer) over a valid/ready interface.
- Counts bytes per frame and flags frame completion (default frame = 390x390 = 152100 bytes).

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- FRAME_BYTES, 152100, bytes per frame; frame_done pulses when this count is reached.
- CNT_W, 18, width of byte_count; must satisfy 2^CNT_W > FRAME_BYTES.

Ports:
- clk  in  1  system clock, same clock as the processor.
- rst  in  1  synchronous, active-high reset.
- GPIO  in  8  processor GPIO data byte.
- GPIOEn  in  1  processor GPIO enable; a falling edge commits the byte.
- out_data  out  8  FIFO head byte; valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid=1 on this edge.
- fifo_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- byte_count  out  CNT_W  strobes detected in the current frame.
- frame_done  out  1  one-cycle pulse on completion of a frame.

Behaviour:
- Reset (rst=1 at a clk edge), synchronous:
  - Pointers and fifo_count cleared to 0; out_valid=0.
  - overflow=0, byte_count=0, frame_done=0.
  - en_q=0, hold_q=8'h00. FIFO memory contents are don't-care.
  - rst takes priority over every event in the same cycle.
  - Reset mid-frame discards buffered data and restarts the count.
- Edge detect:
  - en_q registers GPIOEn every cycle.
  - fall = en_q & ~GPIOEn, combinational.
  - en_q resets to 0, so no fall can occur before GPIOEn has been sampled high after reset.
- Data hold:
  - hold_q <= GPIO on every edge where GPIOEn=1; otherwise it holds.
  - The byte pushed on a fall is hold_q, i.e. GPIO as sampled on the last edge with GPIOEn=1.
  - GPIO value during the fall cycle is ignored.
  - A GPIOEn high pulse of one cycle is sufficient.
- Push/pop:
  - push_req = fall.
  - pop = out_valid & out_ready.
  - Push is accepted when fifo_count<DEPTH, or when fifo_count==DEPTH and pop=1 in the same cycle.
  - A rejected push sets overflow=1 (sticky until rst); the byte is dropped.
- Occupancy and pointers:
  - Accepted push: write mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - Pop: rd_ptr increments, wrapping modulo DEPTH.
  - Push and pop in the same cycle: fifo_count unchanged; both pointers advance.
- Latency: a byte pushed at edge k is visible at out_data with out_valid=1 from edge k (registered outputs valid after k), i.e. the cycle after the fall cycle.
- Output: show-ahead, out_data = mem[rd_ptr]; out_valid = (fifo_count!=0).
- Empty: pop is impossible since out_valid=0; out_ready is ignored.
- Byte counter:
  - Increments on every fall, accepted or dropped.
  - On a fall with byte_count==FRAME_BYTES-1: byte_count wraps to 0 and frame_done=1 for exactly the following cycle.
  - frame_done is 0 at all other times.
- GPIOEn held high: no push. Held low: no push.
- Back-to-back 1,0,1,0 toggling: one push per falling edge, maximum one push per 2 cycles.

Test Plan:
- Reset, then GPIO=8'hA5 with GPIOEn=1 for 1 cycle, then GPIOEn=0 with GPIO=8'hFF. Required: out_valid=1 and out_data=8'hA5 on the cycle after the fall; fifo_count=1; byte_count=1.
- GPIOEn held high 5 cycles (GPIO=8'h3C) and low 5 cycles with out_ready=1. Required: exactly one byte 8'h3C is delivered, then out_valid=0.
- 17 strobes with bytes 0..16 and out_ready=0, DEPTH=16. Required: fifo_count=16, overflow=1, byte 16 dropped. Then out_ready=1 drains exactly 0..15 in order; out_valid=0 afterwards.
- FIFO full, out_ready=1, and a strobe carrying 8'h77 falls in the same cycle as a pop. Required: overflow stays 0, fifo_count stays 16, and 8'h77 is read last.
- FRAME_BYTES=4 with 5 strobes. Required: frame_done pulses exactly one cycle after the 4th fall; byte_count sequence 1,2,3,0,1.
- rst asserted with 3 bytes buffered and GPIOEn falling in the same cycle. Required: next cycle fifo_count=0, out_valid=0, byte_count=0, overflow=0; no byte pushed.
